alu_arbiter_seq: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared registered 4-bit ALU (ALUwithReg). It captures one requester's operands and function code, pulses the ALU enable, and waits a fixed ALU latency. It then returns the registered result and carry to the granted requester with a one-cycle done strobe. Sits between the datapath units that need arithmetic and the single ALU instance.

---
 rtl/alu_arbiter_seq_if.sv | 45 ++++
 rtl/alu_arbiter_seq.sv | 125 ++++++++++++
 tb/tb_alu_arbiter_seq.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_seq_if.sv
// alu_arbiter_seq_if
// Bundles the two requester channels and the shared-ALU channel of the
// alu_arbiter_seq block.
//   slave  : the arbiter side (takes requests and ALU results, drives
//            grants, done strobes, result fields and ALU operands)
//   master : the requester/ALU side (drives requests and ALU results)
// Parameter W is the operand/result width.
interface alu_arbiter_seq_if #(
    parameter int W = 4
);
    logic         req0;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic [3:0]   fun0;
    logic         req1;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic [3:0]   fun1;
    logic         gnt0;
    logic         gnt1;
    logic         done0;
    logic         done1;
    logic [W-1:0] res;
    logic         carry;
    logic         err;
    logic         busy;
    logic         alu_en;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [3:0]   alu_fun;
    logic [W-1:0] alu_out;
    logic         alu_carry;

    modport slave (
        input  req0, a0, b0, fun0, req1, a1, b1, fun1, alu_out, alu_carry,
        output gnt0, gnt1, done0, done1, res, carry, err, busy,
               alu_en, alu_a, alu_b, alu_fun
    );

    modport master (
        output req0, a0, b0, fun0, req1, a1, b1, fun1, alu_out, alu_carry,
        input  gnt0, gnt1, done0, done1, res, carry, err, busy,
               alu_en, alu_a, alu_b, alu_fun
    );
endinterface

// File: rtl/alu_arbiter_seq.sv
// alu_arbiter_seq
// Round-robin arbiter and sequencer for the shared registered ALU. Grants
// one of two requesters, captures its operands, pulses the ALU enable,
// waits ALU_LAT cycles, then returns the registered result/carry with a
// one-cycle done strobe to the owner.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - alu_arbiter_seq_if.slave: requester channels (req/a/b/fun),
//          grant and done strobes, res/carry/err, busy, ALU channel
// Parameters: ALU_LAT (1..15) ALU latency, W operand width.
// Optional build macro RSVD_OP_TRAP_EN: reserved function codes are
// answered directly with err=1 and never reach the ALU.
//
// state | meaning
// IDLE  | waiting for a request; grant issued combinationally
// ISSUE | alu_en high with captured operands, counter loaded
// WAIT  | counting down the ALU latency, result captured on last edge
// DONE  | done strobe to the owner, res/carry/err valid
module alu_arbiter_seq #(
    parameter int ALU_LAT = 2,
    parameter int W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    alu_arbiter_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t       state_q, state_d;
    logic         owner_q;
    logic         prio_q;      // 0: requester 0 wins a tie, 1: requester 1
    logic [3:0]   cnt_q;
    logic [W-1:0] a_q, b_q, res_q;
    logic [3:0]   fun_q;
    logic         carry_q;
    logic         err_q;

    logic         gnt0, gnt1, grant, sel, sel_rsvd;
    logic [W-1:0] sel_a, sel_b;
    logic [3:0]   sel_fun;

    assign gnt0  = (state_q == IDLE) && bus.req0 && (!bus.req1 || !prio_q);
    assign gnt1  = (state_q == IDLE) && bus.req1 && (!bus.req0 ||  prio_q);
    assign grant = gnt0 || gnt1;
    assign sel   = gnt1;

    assign sel_a   = sel ? bus.a1   : bus.a0;
    assign sel_b   = sel ? bus.b1   : bus.b0;
    assign sel_fun = sel ? bus.fun1 : bus.fun0;

`ifdef RSVD_OP_TRAP_EN
    // Reserved: 0110, 0111 and 1010..1111.
    assign sel_rsvd = (sel_fun[3:1] == 3'b011) || (sel_fun[3] && (sel_fun[2] || sel_fun[1]));
`else
    assign sel_rsvd = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = sel_rsvd ? DONE : ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (cnt_q == 4'd1) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            cnt_q   <= 4'd0;
            a_q     <= '0;
            b_q     <= '0;
            fun_q   <= 4'd0;
            res_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        owner_q <= sel;
                        prio_q  <= gnt0;
                        a_q     <= sel_a;
                        b_q     <= sel_b;
                        fun_q   <= sel_fun;
                        if (sel_rsvd) begin
                            res_q   <= '0;
                            carry_q <= 1'b0;
                            err_q   <= 1'b1;
                        end
                    end
                end
                ISSUE: cnt_q <= 4'(ALU_LAT);
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        res_q   <= bus.alu_out;
                        carry_q <= bus.alu_carry;
                        err_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt0    = gnt0;
    assign bus.gnt1    = gnt1;
    assign bus.done0   = (state_q == DONE) && !owner_q;
    assign bus.done1   = (state_q == DONE) &&  owner_q;
    assign bus.res     = res_q;
    assign bus.carry   = carry_q;
    assign bus.err     = err_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.alu_en  = (state_q == ISSUE);
    assign bus.alu_a   = a_q;
    assign bus.alu_b   = b_q;
    assign bus.alu_fun = fun_q;
endmodule

// File: tb/tb_alu_arbiter_seq.sv
module tb_alu_arbiter_seq;
    localparam int ALU_LAT = 2;
    localparam int W       = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_arbiter_seq_if #(.W(W)) bus ();
    alu_arbiter_seq #(.ALU_LAT(ALU_LAT), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic logic [W:0] alu_f(logic [W-1:0] a, logic [W-1:0] b, logic [3:0] f);
        case (f)
            4'b1000: return {1'b0, a} + {1'b0, b};
            4'b1001: return {1'b0, a} - {1'b0, b};
            4'b0000: return {1'b0, a & b};
            4'b0001: return {1'b0, a | b};
            4'b0010: return {1'b0, a ^ b};
            4'b0011: return {1'b0, ~a};
            4'b0100: return {a, 1'b0};
            4'b0101: return {a[0], 1'b0, a[W-1:1]};
            default: return {1'b0, a} + {1'b0, b} + 5'd1;
        endcase
    endfunction

    function automatic logic is_rsvd(logic [3:0] f);
`ifdef RSVD_OP_TRAP_EN
        return (f inside {4'd6, 4'd7, [4'd10:4'd15]});
`else
        return 1'b0;
`endif
    endfunction

    // ALU model: result appears ALU_LAT cycles after the enable cycle;
    // garbage is shifted in otherwise so mistimed capture is visible.
    logic [W:0] pipe [ALU_LAT];
    always @(posedge clk) begin
        pipe[0] <= bus.alu_en ? alu_f(bus.alu_a, bus.alu_b, bus.alu_fun) : 5'($urandom);
        for (int i = 1; i < ALU_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.alu_out   = pipe[ALU_LAT-1][W-1:0];
    assign bus.alu_carry = pipe[ALU_LAT-1][W];

    typedef struct {
        logic         owner;
        logic [W-1:0] a, b, res;
        logic [3:0]   fun;
        logic         carry, err, rsvd;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errors = 0;
    int   cyc = 0, gnt_cyc = 0, prev_gnt = 0, ngrants = 0;
    logic have_prev = 1'b0, contend = 1'b0;
    logic tb_prio = 1'b0;
    logic saw_g0 = 1'b0, saw_g1 = 1'b0, hold0 = 1'b0, hold1 = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic observe();
        exp_t e;
        logic eg0, eg1;
        logic [W:0] r;
        cyc++;
        if (!bus.busy) begin
            eg0 = bus.req0 && (!bus.req1 || !tb_prio);
            eg1 = bus.req1 && (!bus.req0 ||  tb_prio);
            chk("gnt_idle", 32'({bus.gnt1, bus.gnt0}), 32'({eg1, eg0}));
        end else begin
            chk("gnt_busy", 32'({bus.gnt1, bus.gnt0}), 32'(0));
        end
        if (bus.gnt0 || bus.gnt1) begin
            e.owner = bus.gnt1;
            e.a     = e.owner ? bus.a1   : bus.a0;
            e.b     = e.owner ? bus.b1   : bus.b0;
            e.fun   = e.owner ? bus.fun1 : bus.fun0;
            e.rsvd  = is_rsvd(e.fun);
            if (e.rsvd) begin
                e.res = '0; e.carry = 1'b0; e.err = 1'b1; e.lat = 1;
            end else begin
                r = alu_f(e.a, e.b, e.fun);
                e.res = r[W-1:0]; e.carry = r[W]; e.err = 1'b0; e.lat = ALU_LAT + 2;
            end
            sb.push_back(e);
            if (contend && have_prev) chk("gnt_spacing", 32'(cyc - prev_gnt), 32'(ALU_LAT + 3));
            prev_gnt = cyc; have_prev = 1'b1; gnt_cyc = cyc; ngrants++;
            tb_prio = !e.owner;
            saw_g0 = bus.gnt0; saw_g1 = bus.gnt1;
        end
        if (bus.alu_en) begin
            if (sb.size() == 0) chk("alu_en_spurious", 32'(1), 32'(0));
            else begin
                chk("alu_en_cycle", 32'(cyc - gnt_cyc), 32'(1));
                chk("alu_en_rsvd", 32'(sb[0].rsvd), 32'(0));
                chk("alu_operands", 32'({bus.alu_a, bus.alu_b, bus.alu_fun}),
                    32'({sb[0].a, sb[0].b, sb[0].fun}));
            end
        end
        if (bus.done0 || bus.done1) begin
            if (sb.size() == 0) chk("done_spurious", 32'({bus.done1, bus.done0}), 32'(0));
            else begin
                e = sb.pop_front();
                chk("done_owner", 32'({bus.done1, bus.done0}), e.owner ? 32'(2) : 32'(1));
                chk("done_latency", 32'(cyc - gnt_cyc), 32'(e.lat));
                chk("res", 32'(bus.res), 32'(e.res));
                chk("carry", 32'(bus.carry), 32'(e.carry));
                chk("err", 32'(bus.err), 32'(e.err));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        if (saw_g0 && !hold0) bus.req0 = 1'b0;
        if (saw_g1 && !hold1) bus.req1 = 1'b0;
        saw_g0 = 1'b0; saw_g1 = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((sb.size() != 0 || bus.busy || bus.req0 || bus.req1) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(sb.size() != 0 || bus.busy || bus.req0 || bus.req1), 32'(0));
    endtask

    task automatic check_all_zero(input string tag);
        chk(tag, 32'({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.res, bus.carry, bus.err}), 32'(0));
        chk({tag, "_busy_en"}, 32'({bus.busy, bus.alu_en}), 32'(0));
        chk({tag, "_alu_ops"}, 32'({bus.alu_a, bus.alu_b, bus.alu_fun}), 32'(0));
    endtask

    initial begin
        int n, start, sel;
        rst = 1'b1;
        bus.req0 = 1'b0; bus.a0 = '0; bus.b0 = '0; bus.fun0 = 4'd0;
        bus.req1 = 1'b0; bus.a1 = '0; bus.b1 = '0; bus.fun1 = 4'd0;
        #3;
        check_all_zero("reset_state");
        #5 rst = 1'b0;
        #1 check_all_zero("after_release");
        tick();

        // Single add 7+9 -> res 0, carry 1, done0 at cycle 4
        bus.a0 = 4'd7; bus.b0 = 4'd9; bus.fun0 = 4'b1000; bus.req0 = 1'b1;
        drain(20);
        chk("carry_held", 32'(bus.carry), 32'(1));

        // Contention: both held, grants alternate, spaced ALU_LAT+3
        hold0 = 1'b1; hold1 = 1'b1; contend = 1'b1; have_prev = 1'b0;
        bus.a0 = 4'd3; bus.b0 = 4'd12; bus.fun0 = 4'b0001;
        bus.a1 = 4'd5; bus.b1 = 4'd8;  bus.fun1 = 4'b0001;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        start = ngrants; n = 0;
        while (ngrants - start < 4 && n < 60) begin tick(); n++; end
        chk("contention_grants", 32'(ngrants - start), 32'(4));
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        hold0 = 1'b0; hold1 = 1'b0; contend = 1'b0;
        drain(20);

        // Withdrawal: req1 pulses one cycle while busy
        bus.a0 = 4'd10; bus.b0 = 4'd6; bus.fun0 = 4'b0010; bus.req0 = 1'b1;
        tick(); tick(); tick();
        bus.a1 = 4'd1; bus.b1 = 4'd1; bus.fun1 = 4'b1000; bus.req1 = 1'b1;
        tick();
        bus.req1 = 1'b0;
        drain(20);
        for (int i = 0; i < 4; i++) tick();

        // Reset mid-op at cycle 2
        bus.a0 = 4'd3; bus.b0 = 4'd5; bus.fun0 = 4'b1001; bus.req0 = 1'b1;
        tick(); tick();
        chk("busy_before_reset", 32'(bus.busy), 32'(1));
        #1 rst = 1'b1;
        #2 check_all_zero("reset_mid_op");
        #4 rst = 1'b0;
        sb.delete(); tb_prio = 1'b0;
        tick();
        bus.a0 = 4'd15; bus.b0 = 4'd1; bus.fun0 = 4'b1000; bus.req0 = 1'b1;
        bus.a1 = 4'd2;  bus.b1 = 4'd2; bus.fun1 = 4'b0100; bus.req1 = 1'b1;
        tick();
        chk("post_reset_owner0", 32'(sb.size() == 1 && sb[0].owner == 1'b0), 32'(1));
        drain(30);

        // Reserved function code
        bus.a0 = 4'd5; bus.b0 = 4'd3; bus.fun0 = 4'b0110; bus.req0 = 1'b1;
        drain(20);

        // Mixed directed-random traffic
        for (int k = 0; k < 10; k++) begin
            sel = $urandom_range(0, 2);
            bus.a0 = 4'($urandom); bus.b0 = 4'($urandom); bus.fun0 = 4'($urandom);
            bus.a1 = 4'($urandom); bus.b1 = 4'($urandom); bus.fun1 = 4'($urandom);
            bus.req0 = (sel != 1);
            bus.req1 = (sel != 0);
            drain(40);
        end

        chk("scoreboard_empty", 32'(sb.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
